// File: rtl/sim_uart_in_feeder_if.sv
// sim_uart_in_feeder_if: host push channel plus DUT read-strobe channel of the UART input feeder.
interface sim_uart_in_feeder_if;
    logic       push_valid;
    logic [7:0] push_ch;
    logic       push_ready;
    logic       uart_in_valid;
    logic [7:0] uart_in_ch;
    modport master (output push_valid, push_ch, uart_in_valid, input push_ready, uart_in_ch);
    modport slave  (input push_valid, push_ch, uart_in_valid, output push_ready, uart_in_ch);
endinterface

// File: rtl/sim_uart_in_feeder.sv
// sim_uart_in_feeder: FIFO-buffered UART character source answering the DUT read strobe,
// with optional pacing that enforces a minimum idle gap between delivered characters.
module sim_uart_in_feeder #(
    parameter int         DEPTH      = 16,
    parameter int         GAP_CYCLES = 0,
    parameter logic [7:0] IDLE_CH    = 8'hff
) (
    input  logic                       clock,
    input  logic                       reset,
    sim_uart_in_feeder_if.slave        bus,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [31:0]                delivered_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic {READY, COOLDOWN} state_t;

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [GW-1:0] gap_q;
    state_t        state_q;
    logic          overflow_q;
    logic [31:0]   delivered_q;
    logic          empty, full, push, deliver;

    assign empty   = wptr_q == rptr_q;
    assign full    = (wptr_q ^ rptr_q) == {1'b1, {AW{1'b0}}};
    assign push    = bus.push_valid && !full && !flush;
    assign deliver = state_q == READY && bus.uart_in_valid && !empty && !flush;

    assign bus.push_ready = !full;
    assign bus.uart_in_ch = deliver ? mem_q[rptr_q[AW-1:0]] : IDLE_CH;
    assign count          = wptr_q - rptr_q;
    assign overflow       = overflow_q;
    assign delivered_cnt  = delivered_q;

    always_comb begin
        wptr_d = flush ? '0 : wptr_q + PW'(push);
        rptr_d = flush ? '0 : rptr_q + PW'(deliver);
    end

    // Storage carries no reset; only the pointers define which entries are live.
    always_ff @(posedge clock)
        if (push && reset) mem_q[wptr_q[AW-1:0]] <= bus.push_ch;

    always_ff @(posedge clock) begin
        if (!reset) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            state_q     <= READY;
            gap_q       <= '0;
            overflow_q  <= 1'b0;
            delivered_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            if (bus.push_valid && full && !flush) overflow_q <= 1'b1;
            if (deliver) delivered_q <= delivered_q + 32'd1;
            if (flush) begin
                state_q <= READY;
                gap_q   <= '0;
            end else if (state_q == READY) begin
                if (deliver && GAP_CYCLES > 0) begin
                    state_q <= COOLDOWN;
                    gap_q   <= GW'(GAP_CYCLES - 1);
                end
            end else begin
                // Cooldown runs down regardless of strobes; leave on the cycle after reaching zero.
                state_q <= gap_q == '0 ? READY : COOLDOWN;
                gap_q   <= gap_q == '0 ? '0 : gap_q - GW'(1);
            end
        end
    end
endmodule

// File: tb/tb_sim_uart_in_feeder.sv
// tb_sim_uart_in_feeder: scoreboard bench over three feeders paced with gaps of 0, 3 and 5 cycles.
module tb_sim_uart_in_feeder;
    logic        clock = 1'b0;
    logic [2:0]  rn = 3'b000, pv = 3'b000, sv = 3'b000, fl = 3'b000, pr, ov;
    logic [7:0]  pc [3];
    logic [7:0]  ch [3];
    logic [4:0]  cnt [3];
    logic [31:0] dc [3];
    logic [7:0]  q [3][$];
    logic [7:0]  e;
    int          checks = 0, errors = 0;

    always #5 clock = ~clock;

    for (genvar g = 0; g < 3; g++) begin : d
        sim_uart_in_feeder_if b ();
        assign b.push_valid    = pv[g];
        assign b.push_ch       = pc[g];
        assign b.uart_in_valid = sv[g];
        assign pr[g]           = b.push_ready;
        assign ch[g]           = b.uart_in_ch;
        sim_uart_in_feeder #(.DEPTH(16), .GAP_CYCLES(g == 0 ? 0 : (g == 1 ? 3 : 5)), .IDLE_CH(8'hff)) u (
            .clock(clock), .reset(rn[g]), .bus(b.slave), .flush(fl[g]),
            .count(cnt[g]), .overflow(ov[g]), .delivered_cnt(dc[g]));
    end

    always @(negedge clock)
        for (int i = 0; i < 3; i++)
            if (rn[i] && sv[i]) begin
                checks++;
                if (q[i].size() == 0) begin
                    errors++;
                    $display("FAIL strobe%0d unexpected strobe got %h", i, ch[i]);
                end else begin
                    e = q[i].pop_front();
                    if (ch[i] !== e) begin
                        errors++;
                        $display("FAIL strobe%0d got %h expected %h", i, ch[i], e);
                    end
                end
            end

    task automatic chk(string n, logic [31:0] a, logic [31:0] x);
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", n, a, x);
        end
    endtask

    task automatic step(int k, bit v, logic [7:0] c, bit s, bit f, logic [7:0] x);
        pv[k] = v; pc[k] = c; sv[k] = s; fl[k] = f;
        if (s) q[k].push_back(x);
        @(posedge clock); #1;
        pv[k] = 0; sv[k] = 0; fl[k] = 0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) pc[i] = 8'h00;
        repeat (2) @(posedge clock);
        #1 rn = 3'b111;
        chk("reset_count", cnt[0], 0);
        chk("reset_ready", pr[0], 1);
        chk("reset_ovf", ov[0], 0);
        for (int k = 0; k < 20; k++) step(0, 0, 8'h00, 1, 0, 8'hff);
        chk("idle_dc", dc[0], 0);
        chk("idle_ready", pr[0], 1);
        step(0, 1, 8'h41, 0, 0, 8'hff);
        step(0, 1, 8'h42, 1, 0, 8'h41);
        step(0, 1, 8'h43, 1, 0, 8'h42);
        step(0, 0, 8'h00, 1, 0, 8'h43);
        step(0, 0, 8'h00, 1, 0, 8'hff);
        chk("abc_dc", dc[0], 3);
        chk("abc_count", cnt[0], 0);
        for (int k = 0; k < 4; k++) step(1, 1, 8'h10 + 8'(k), 0, 0, 8'hff);
        chk("gap3_count4", cnt[1], 4);
        for (int k = 0; k < 13; k++) begin
            step(1, 0, 8'h00, 1, 0, (k % 4 == 0) ? 8'h10 + 8'(k / 4) : 8'hff);
            if (k % 4 == 0) chk("gap3_count", cnt[1], 32'(3 - k / 4));
        end
        chk("gap3_dc", dc[1], 4);
        for (int k = 1; k <= 17; k++) begin
            step(0, 1, 8'(k), 0, 0, 8'hff);
            if (k >= 15) chk("fill_ready", pr[0], k < 16);
        end
        chk("fill_ovf", ov[0], 1);
        chk("fill_count", cnt[0], 16);
        step(0, 1, 8'hee, 1, 0, 8'h01);
        chk("full_nobypass_count", cnt[0], 15);
        for (int k = 2; k <= 16; k++) step(0, 0, 8'h00, 1, 0, 8'(k));
        step(0, 0, 8'h00, 1, 0, 8'hff);
        for (int k = 0; k < 16; k++) step(0, 1, 8'h80 + 8'(k), 0, 0, 8'hff);
        chk("fill2_ready", pr[0], 0);
        for (int k = 0; k < 16; k++) step(0, 0, 8'h00, 1, 0, 8'h80 + 8'(k));
        chk("fill2_dc", dc[0], 35);
        chk("fill2_ovf_sticky", ov[0], 1);
        for (int k = 0; k < 5; k++) step(0, 1, 8'h50 + 8'(k), 0, 0, 8'hff);
        chk("flush_pre_count", cnt[0], 5);
        step(0, 1, 8'h99, 1, 1, 8'hff);
        chk("flush_count", cnt[0], 0);
        chk("flush_ovf", ov[0], 1);
        chk("flush_dc", dc[0], 35);
        step(0, 0, 8'h00, 1, 0, 8'hff);
        step(0, 1, 8'h77, 0, 0, 8'hff);
        step(0, 0, 8'h00, 1, 0, 8'h77);
        step(2, 1, 8'h61, 0, 0, 8'hff);
        step(2, 0, 8'h00, 1, 0, 8'h61);
        step(2, 0, 8'h00, 1, 0, 8'hff);
        step(2, 1, 8'h6a, 0, 0, 8'hff);
        rn[2] = 0;
        step(2, 1, 8'h62, 0, 0, 8'hff);
        rn[2] = 1;
        chk("rst_dc", dc[2], 0);
        chk("rst_count", cnt[2], 0);
        chk("rst_ovf", ov[2], 0);
        step(2, 1, 8'h63, 0, 0, 8'hff);
        step(2, 0, 8'h00, 1, 0, 8'h63);
        chk("rst_deliver_dc", dc[2], 1);
        step(2, 1, 8'h64, 1, 0, 8'hff);
        for (int k = 0; k < 4; k++) step(2, 0, 8'h00, 1, 0, 8'hff);
        step(2, 0, 8'h00, 1, 0, 8'h64);
        chk("gap5_dc", dc[2], 2);
        for (int i = 0; i < 3; i++) chk("queue_drained", q[i].size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
